// File: rtl/fact_pkg.sv
// Shared definitions for the factorial engine: register indices, CTRL/STATUS bit
// positions and the engine state enum.
package fact_pkg;

    localparam logic [2:0] RegCtrl    = 3'd0;
    localparam logic [2:0] RegStatus  = 3'd1;
    localparam logic [2:0] RegIntrEn  = 3'd2;
    localparam logic [2:0] RegOperand = 3'd3;
    localparam logic [2:0] RegResultH = 3'd4;
    localparam logic [2:0] RegResultL = 3'd5;
    localparam logic [2:0] RegIter    = 3'd6;
    localparam logic [2:0] RegVersion = 3'd7;

    localparam int unsigned CtrlStart = 0;
    localparam int unsigned CtrlClr   = 1;

    localparam int unsigned StatBusy = 0;
    localparam int unsigned StatDone = 1;
    localparam int unsigned StatOvf  = 2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StDone = 2'd2
    } fact_state_e;

endpackage

// File: rtl/fact_mul_step.sv
// One factorial step: 64x32 multiply keeping the low 64 bits and flagging overflow.
// With FACT_SATURATE_EN defined the product saturates to all ones once overflow occurs.
module fact_mul_step (
    input  logic [63:0] acc_i,
    input  logic [31:0] mult_i,
`ifdef FACT_SATURATE_EN
    input  logic        sat_i,
`endif
    output logic [63:0] prod_o,
    output logic        ovf_o
);

    logic [95:0] prod_full;

    assign prod_full = {32'd0, acc_i} * {64'd0, mult_i};
    assign ovf_o     = |prod_full[95:64];

`ifdef FACT_SATURATE_EN
    // Saturation sticks for the whole computation via the caller's overflow flag.
    assign prod_o = (sat_i || ovf_o) ? {64{1'b1}} : prod_full[63:0];
`else
    assign prod_o = prod_full[63:0];
`endif

endmodule

// File: rtl/fact_reg_core.sv
// Register-mapped iterative factorial engine feeding an external 8-to-1 read mux.
// Build option FACT_SATURATE_EN selects saturating instead of modulo-2^64 results.
module fact_reg_core
    import fact_pkg::*;
#(
    parameter logic [31:0] VERSION_ID = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s_sel,
    input  logic        s_wr,
    input  logic [2:0]  s_addr,
    input  logic [31:0] s_din,
    output logic [31:0] reg_a,
    output logic [31:0] reg_b,
    output logic [31:0] reg_c,
    output logic [31:0] reg_d,
    output logic [31:0] reg_e,
    output logic [31:0] reg_f,
    output logic [31:0] reg_g,
    output logic [31:0] reg_h,
    output logic [2:0]  rd_sel,
    output logic        interrupt
);

    fact_state_e state_q;
    logic [31:0] operand_q;
    logic [63:0] result_q;
    logic [31:0] iter_q;
    logic        intr_en_q;
    logic        done_q;
    logic        ovf_q;
    logic [2:0]  rd_sel_q;

    logic        wr_acc;
    logic        rd_acc;
    logic        start;
    logic        clr;
    logic        busy;
    logic [63:0] step_prod;
    logic        step_ovf;

    assign wr_acc = s_sel & s_wr;
    assign rd_acc = s_sel & ~s_wr;
    assign start  = wr_acc && (s_addr == RegCtrl) && s_din[CtrlStart];
    assign clr    = wr_acc && (s_addr == RegCtrl) && s_din[CtrlClr];
    assign busy   = (state_q == StMul);

    fact_mul_step u_mul_step (
        .acc_i  (result_q),
        .mult_i (iter_q),
`ifdef FACT_SATURATE_EN
        .sat_i  (ovf_q),
`endif
        .prod_o (step_prod),
        .ovf_o  (step_ovf)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            operand_q <= 32'd0;
            result_q  <= 64'd0;
            iter_q    <= 32'd0;
            intr_en_q <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            rd_sel_q  <= 3'd0;
        end else begin
            if (rd_acc) begin
                rd_sel_q <= s_addr;
            end
            if (wr_acc && (s_addr == RegIntrEn)) begin
                intr_en_q <= s_din[0];
            end
            if (wr_acc && (s_addr == RegOperand) && !busy) begin
                operand_q <= s_din;
            end
            // Clear has priority over start and aborts any running computation.
            if (clr) begin
                state_q  <= StIdle;
                result_q <= 64'd0;
                iter_q   <= 32'd0;
                done_q   <= 1'b0;
                ovf_q    <= 1'b0;
            end else begin
                case (state_q)
                    StIdle, StDone: begin
                        if (start) begin
                            state_q  <= StMul;
                            result_q <= 64'd1;
                            iter_q   <= operand_q;
                            done_q   <= 1'b0;
                            ovf_q    <= 1'b0;
                        end
                    end
                    StMul: begin
                        if (iter_q > 32'd1) begin
                            result_q <= step_prod;
                            iter_q   <= iter_q - 32'd1;
                            if (step_ovf) begin
                                ovf_q <= 1'b1;
                            end
                        end else begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign reg_a     = 32'd0;
    assign reg_b     = {29'd0, ovf_q, done_q, busy};
    assign reg_c     = {31'd0, intr_en_q};
    assign reg_d     = operand_q;
    assign reg_e     = result_q[63:32];
    assign reg_f     = result_q[31:0];
    assign reg_g     = iter_q;
    assign reg_h     = VERSION_ID;
    assign rd_sel    = rd_sel_q;
    assign interrupt = done_q & intr_en_q;

endmodule

// File: doc/fact_reg_core.md
# fact_reg_core

Register-mapped factorial engine for the factorial machine. It takes bus writes into its register bank and computes N! iteratively into a 64-bit result. It drives the eight 32-bit register values and a registered read-select directly into the downstream 8-to-1 read multiplexer. That multiplexer returns the selected register as bus read data.

## Interface
Parameters:
- VERSION_ID, 32'h0001_0000, constant returned by register 7.

Ports:
- clk  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- s_sel  in  1  slave select; access valid when 1
- s_wr  in  1  1 = write, 0 = read (qualified by s_sel)
- s_addr  in  3  register index
- s_din  in  32  write data
- reg_a .. reg_h  out  32 each  register 0..7 values, wired to mux inputs a..h
- rd_sel  out  3  registered read index, wired to mux sel
- interrupt  out  1  level interrupt

Clock and reset are fixed: one clock; reset is asynchronous and active-low.

## Operation
Register map:
- 0 CTRL, W. bit0 start and bit1 clear are write-1 pulses. Reads as 0.
- 1 STATUS, RO. bit0 busy, bit1 done, bit2 overflow; other bits 0.
- 2 INTR_EN, RW. Only bit0 is stored.
- 3 OPERAND, RW. Holds N. A write while busy is ignored.
- 4 RESULT_H, RO. Result bits [63:32].
- 5 RESULT_L, RO. Result bits [31:0].
- 6 ITER, RO. Current multiplier m.
- 7 VERSION, RO. Returns VERSION_ID.
- Writes to RO indices are ignored.

State machine:
- States are IDLE, MUL and DONE.
- IDLE/DONE → MUL on a start write. On entry, result=1, m=OPERAND, overflow=0, done=0.
- MUL → MUL while m>1: result ← low64(result×m), m ← m−1.
- MUL → DONE when m≤1: done=1, result held.
- Any state → IDLE on a clear write: result=0, m=0, done=0, overflow=0. Clear aborts a running computation.

Arithmetic and flags:
- The product is 96 bits wide. Overflow is set when bits [95:64] are nonzero, and stays set until the next start or clear.
- busy = (state==MUL).
- interrupt = done & INTR_EN[0], combinational from registered flops.

Access rules:
- A start write while busy is ignored.
- A single write with both start and clear set: clear wins.
- rd_sel ← s_addr on any cycle with s_sel=1 and s_wr=0; otherwise it holds.

## Timing
- Reset values: all stored registers are 0, rd_sel=0, interrupt=0, state=IDLE. reg_h = VERSION_ID at all times.
- Write and state effects appear on the edge that samples the access and are visible the next cycle.
- Read data is valid at the mux output one cycle after the read access, once rd_sel has updated.
- Start accepted at edge t: busy=1 from t+1. done=1 and busy=0 from t+1+max(N,1).
  - N=5 → done at t+6.
  - N=0 or N=1 → done at t+2, result 1.
- If reset_n is asserted mid-computation, all state is cleared immediately and no interrupt results.
- A start while in DONE restarts from the current OPERAND and drops done on the next edge.

## Configuration
- FACT_SATURATE_EN defined: once overflow sets, result is forced to 64'hFFFF_FFFF_FFFF_FFFF and held for the rest of that computation.
- FACT_SATURATE_EN undefined: result keeps the truncated low 64 bits (modulo 2^64).
- The overflow flag behaves identically in both builds.

## Structure
- Shared package fact_pkg holds:
  - register index constants 0..7
  - CTRL bit positions (START=0, CLR=1)
  - STATUS bit positions
  - the state enum (IDLE, MUL, DONE)
- Sub-module fact_mul_step: combinational 64×32 multiply. It outputs the low 64 bits and an overflow bit, and applies saturation under the macro.

## Test plan
- Reset, then read each index 0..7 → all 0 except index 7 = 32'h0001_0000. interrupt=0.
- OPERAND=5, INTR_EN=1, start at edge t → busy from t+1, done and interrupt from t+6, RESULT_L=120, RESULT_H=0, overflow=0.
- OPERAND=20 → result 64'h21C3_677C_82B4_0000, overflow=0.
- OPERAND=21 → overflow=1. With the macro, result is all ones; without it, result is low64(21!) = 64'hC507_7D36_B8C4_0000.
- OPERAND=0 and OPERAND=1 → done 2 cycles after start, result 1.
- Start N=10, write OPERAND=3 and start at cycle 3 → both ignored. Clear at cycle 5 → IDLE, result 0, busy 0, no done. A write with start and clear together → IDLE.
